// File: rtl/axi4_burst_addr_gen.sv
// Per-beat AXI4 address sequencer: takes one AR/AW request and presents len+1 beats
// with address, byte-lane strobe, ID, user, LAST and an illegal-burst error flag.
module axi4_burst_addr_gen #(
    parameter int ADDR_BITS       = 32,
    parameter int LOG2_DATA_BYTES = 3,
    parameter int ID_BITS         = 5,
    parameter int USER_BITS       = 1
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic                            i_req_valid,
    output logic                            o_req_ready,
    input  logic [ADDR_BITS-1:0]            i_req_addr,
    input  logic [7:0]                      i_req_len,
    input  logic [2:0]                      i_req_size,
    input  logic [1:0]                      i_req_burst,
    input  logic [ID_BITS-1:0]              i_req_id,
    input  logic [USER_BITS-1:0]            i_req_user,
    output logic                            o_beat_valid,
    input  logic                            i_beat_ready,
    output logic [ADDR_BITS-1:0]            o_beat_addr,
    output logic [(1<<LOG2_DATA_BYTES)-1:0] o_beat_strb,
    output logic [ID_BITS-1:0]              o_beat_id,
    output logic [USER_BITS-1:0]            o_beat_user,
    output logic                            o_beat_last,
    output logic                            o_beat_err
);
    localparam int         DATA_BYTES = 1 << LOG2_DATA_BYTES;
    localparam logic [2:0] MAX_SIZE   = 3'(LOG2_DATA_BYTES);
    localparam logic [1:0] BURST_FIXED = 2'd0;
    localparam logic [1:0] BURST_INCR  = 2'd1;
    localparam logic [1:0] BURST_WRAP  = 2'd2;

    typedef enum logic {S_IDLE, S_ACTIVE} state_t;
    typedef logic [LOG2_DATA_BYTES:0] lane_t;

    state_t                 state_q, state_d;
    logic                   ready_en_q;
    logic [ADDR_BITS-1:0]   addr_q, lower_q, wsize_q;
    logic [7:0]             cnt_q;
    logic [2:0]             size_q;
    logic [1:0]             burst_q;
    logic [ID_BITS-1:0]     id_q;
    logic [USER_BITS-1:0]   user_q;
    logic                   err_q;

    // Handshakes: a transfer happens on a rising edge where valid && ready are both 1;
    // a producer never drops valid or changes payload until that edge.
    logic req_hs, beat_hs, last_beat;
    assign o_beat_valid = (state_q == S_ACTIVE);
    assign last_beat    = (cnt_q == 8'd0);
    assign beat_hs      = o_beat_valid & i_beat_ready;
    assign o_req_ready  = ready_en_q & ((state_q == S_IDLE) | (beat_hs & last_beat));
    assign req_hs       = i_req_valid & o_req_ready;

    // Request decode, used only on the accepting edge.
    logic [2:0]           req_size_eff;
    logic [ADDR_BITS-1:0] req_bytes, req_aligned, req_wsize, req_lower;
    logic [ADDR_BITS:0]   req_end;
    logic                 wrap_len_ok, page_cross, req_err;

    assign req_size_eff = (i_req_size > MAX_SIZE) ? MAX_SIZE : i_req_size;
    assign req_bytes    = ADDR_BITS'(1) << req_size_eff;
    assign req_aligned  = i_req_addr & ~(req_bytes - ADDR_BITS'(1));
    assign req_wsize    = (ADDR_BITS'(i_req_len) + ADDR_BITS'(1)) << req_size_eff;
    assign req_lower    = i_req_addr & ~(req_wsize - ADDR_BITS'(1));
    // One extra bit so a burst running off the top of the address space counts as a page cross.
    assign req_end      = {1'b0, req_aligned} + {1'b0, req_wsize} - (ADDR_BITS+1)'(1);
    assign page_cross   = (req_end >> 12) != ({1'b0, i_req_addr} >> 12);
    assign wrap_len_ok  = (i_req_len == 8'd1) | (i_req_len == 8'd3) |
                          (i_req_len == 8'd7) | (i_req_len == 8'd15);
    assign req_err      = (i_req_size > MAX_SIZE) | (i_req_burst == 2'd3) |
                          ((i_req_burst == BURST_WRAP) &
                           (!wrap_len_ok | ((i_req_addr & (req_bytes - ADDR_BITS'(1))) != '0))) |
                          ((i_req_burst == BURST_INCR) & page_cross);

    // Per-beat address stepping; the reserved burst type steps like INCR.
    logic [ADDR_BITS-1:0] beat_bytes, beat_aligned, wrap_inc, next_addr;
    assign beat_bytes   = ADDR_BITS'(1) << size_q;
    assign beat_aligned = addr_q & ~(beat_bytes - ADDR_BITS'(1));
    assign wrap_inc     = addr_q + beat_bytes;

    always_comb begin
        next_addr = beat_aligned + beat_bytes;
        case (burst_q)
            BURST_FIXED: next_addr = addr_q;
            BURST_WRAP:  next_addr = (wrap_inc == lower_q + wsize_q) ? lower_q : wrap_inc;
            default:     next_addr = beat_aligned + beat_bytes;
        endcase
    end

    lane_t lane_lo, lane_hi;
    assign lane_lo = {1'b0, addr_q[LOG2_DATA_BYTES-1:0]};
    assign lane_hi = {1'b0, beat_aligned[LOG2_DATA_BYTES-1:0]} +
                     beat_bytes[LOG2_DATA_BYTES:0] - lane_t'(1);

    always_comb begin
        o_beat_strb = '0;
        for (int i = 0; i < DATA_BYTES; i++) begin
            o_beat_strb[i] = o_beat_valid & (lane_t'(i) >= lane_lo) & (lane_t'(i) <= lane_hi);
        end
    end

    assign o_beat_addr = addr_q;
    assign o_beat_id   = id_q;
    assign o_beat_user = user_q;
    assign o_beat_err  = err_q;
    assign o_beat_last = o_beat_valid & last_beat;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (req_hs) state_d = S_ACTIVE;
            S_ACTIVE: if (beat_hs && last_beat) state_d = req_hs ? S_ACTIVE : S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ready_en_q <= 1'b0;
            addr_q     <= '0;
            lower_q    <= '0;
            wsize_q    <= '0;
            cnt_q      <= '0;
            size_q     <= '0;
            burst_q    <= '0;
            id_q       <= '0;
            user_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            ready_en_q <= 1'b1;
            if (req_hs) begin
                addr_q  <= i_req_addr;
                lower_q <= req_lower;
                wsize_q <= req_wsize;
                cnt_q   <= i_req_len;
                size_q  <= req_size_eff;
                burst_q <= i_req_burst;
                id_q    <= i_req_id;
                user_q  <= i_req_user;
                err_q   <= req_err;
            end else if (beat_hs) begin
                addr_q <= next_addr;
                cnt_q  <= cnt_q - 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_axi4_burst_addr_gen.sv
// Directed bench for axi4_burst_addr_gen: requests push hand-computed beats into a
// queue, and a negedge monitor pops and compares every beat the DUT hands over.
module tb_axi4_burst_addr_gen;
    localparam int W = 49; // {chk_addr, addr[32], strb[8], id[5], user, last, err}

    logic        clk, rst;
    logic        i_req_valid, o_req_ready;
    logic [31:0] i_req_addr;
    logic [7:0]  i_req_len;
    logic [2:0]  i_req_size;
    logic [1:0]  i_req_burst;
    logic [4:0]  i_req_id;
    logic [0:0]  i_req_user;
    logic        o_beat_valid, i_beat_ready;
    logic [31:0] o_beat_addr;
    logic [7:0]  o_beat_strb;
    logic [4:0]  o_beat_id;
    logic [0:0]  o_beat_user;
    logic        o_beat_last, o_beat_err;

    axi4_burst_addr_gen dut (
        .i_clk(clk), .i_rst(rst),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
        .i_req_addr(i_req_addr), .i_req_len(i_req_len), .i_req_size(i_req_size),
        .i_req_burst(i_req_burst), .i_req_id(i_req_id), .i_req_user(i_req_user),
        .o_beat_valid(o_beat_valid), .i_beat_ready(i_beat_ready),
        .o_beat_addr(o_beat_addr), .o_beat_strb(o_beat_strb), .o_beat_id(o_beat_id),
        .o_beat_user(o_beat_user), .o_beat_last(o_beat_last), .o_beat_err(o_beat_err)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int           total = 0;
    int           bad = 0;
    int           beats_seen = 0;
    int           rdy_mode = 0; // 0 always ready, 1 low 2 of every 3 cycles, 2 never ready
    int           stall_ph = 0;
    logic [W-1:0] exp_q[$];
    logic [4:0]   cur_id;
    logic [0:0]   cur_user;
    logic         held_v = 1'b0;
    logic [47:0]  held;
    logic         b2b_seen = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic exp_beat(input logic ca, input logic [31:0] a, input logic [7:0] s,
                            input logic last, input logic err);
        exp_q.push_back({ca, a, s, cur_id, cur_user, last, err});
    endtask

    task automatic send_req(input logic [31:0] a, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst);
        logic hs;
        hs = 1'b0;
        i_req_addr = a; i_req_len = len; i_req_size = size; i_req_burst = burst;
        i_req_id = cur_id; i_req_user = cur_user; i_req_valid = 1'b1;
        for (int c = 0; c < 200 && !hs; c++) begin
            @(negedge clk);
            hs = o_req_ready;
            @(posedge clk);
            #1;
        end
        if (!hs) begin
            total++; bad++;
            $display("FAIL req_timeout: got no handshake expected one for addr %0h", a);
        end
        // Scramble request fields after acceptance; the burst must not notice.
        i_req_valid = 1'b0;
        i_req_addr  = $urandom;
        i_req_len   = 8'($urandom_range(0, 255));
        i_req_size  = 3'($urandom_range(0, 7));
        i_req_burst = 2'($urandom_range(0, 3));
        i_req_id    = 5'($urandom_range(0, 31));
    endtask

    task automatic wait_drain();
        logic done;
        done = 1'b0;
        for (int c = 0; c < 300 && !done; c++) begin
            @(posedge clk);
            #2;
            done = (exp_q.size() == 0) && !o_beat_valid;
        end
        if (!done) begin
            total++; bad++;
            $display("FAIL drain_timeout: got %0d beats pending expected 0", exp_q.size());
        end
    endtask

    // beat-ready driver
    always @(posedge clk) begin
        #1;
        stall_ph = (stall_ph + 1) % 3;
        case (rdy_mode)
            0:       i_beat_ready = 1'b1;
            1:       i_beat_ready = (stall_ph == 2);
            default: i_beat_ready = 1'b0;
        endcase
    end

    // monitor / scoreboard
    always @(negedge clk) begin
        logic [W-1:0] e;
        logic [47:0]  cur;
        cur = {o_beat_addr, o_beat_strb, o_beat_id, o_beat_user, o_beat_last, o_beat_err};
        if (!rst && held_v && o_beat_valid) check("stall_stable", 64'(cur), 64'(held));
        held_v = !rst && o_beat_valid && !i_beat_ready;
        held   = cur;
        if (!rst && o_beat_valid && i_beat_ready) begin
            beats_seen++;
            if (exp_q.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_beat: got addr %0h expected no beat", o_beat_addr);
            end else begin
                e = exp_q.pop_front();
                if (e[48]) begin
                    check("beat_addr", 64'(o_beat_addr), 64'(e[47:16]));
                    check("beat_strb", 64'(o_beat_strb), 64'(e[15:8]));
                end
                check("beat_id",   64'(o_beat_id),   64'(e[7:3]));
                check("beat_user", 64'(o_beat_user), 64'(e[2]));
                check("beat_last", 64'(o_beat_last), 64'(e[1]));
                check("beat_err",  64'(o_beat_err),  64'(e[0]));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected one");
        $fatal(1, "global timeout");
    end

    initial begin
        int base;
        rst = 1'b1; i_req_valid = 1'b0; i_beat_ready = 1'b0;
        i_req_addr = '0; i_req_len = '0; i_req_size = '0; i_req_burst = '0;
        i_req_id = '0; i_req_user = '0;
        #2;
        check("rst_req_ready",  64'(o_req_ready),  64'd0);
        check("rst_beat_valid", 64'(o_beat_valid), 64'd0);
        check("rst_beat_last",  64'(o_beat_last),  64'd0);
        check("rst_beat_strb",  64'(o_beat_strb),  64'd0);
        check("rst_beat_addr",  64'(o_beat_addr),  64'd0);
        check("rst_beat_err",   64'(o_beat_err),   64'd0);
        #20 rst = 1'b0;
        #1 check("rel_req_ready_before_clk", 64'(o_req_ready), 64'd0);
        @(posedge clk); #2;
        check("rel_req_ready_after_clk", 64'(o_req_ready), 64'd1);
        #1;

        // 1: INCR unaligned start
        cur_id = 5'd3; cur_user = 1'b1;
        exp_beat(1, 32'h1003, 8'h08, 0, 0);
        exp_beat(1, 32'h1004, 8'hF0, 0, 0);
        exp_beat(1, 32'h1008, 8'h0F, 1, 0);
        send_req(32'h1003, 8'd2, 3'd2, 2'd1);
        wait_drain();

        // 2: WRAP 4 x 8 bytes, then WRAP 8 x 1 byte
        cur_id = 5'd7; cur_user = 1'b0;
        exp_beat(1, 32'h2018, 8'hFF, 0, 0);
        exp_beat(1, 32'h2000, 8'hFF, 0, 0);
        exp_beat(1, 32'h2008, 8'hFF, 0, 0);
        exp_beat(1, 32'h2010, 8'hFF, 1, 0);
        send_req(32'h2018, 8'd3, 3'd3, 2'd2);
        cur_id = 5'd9;
        exp_beat(1, 32'h1005, 8'h20, 0, 0);
        exp_beat(1, 32'h1006, 8'h40, 0, 0);
        exp_beat(1, 32'h1007, 8'h80, 0, 0);
        exp_beat(1, 32'h1000, 8'h01, 0, 0);
        exp_beat(1, 32'h1001, 8'h02, 0, 0);
        exp_beat(1, 32'h1002, 8'h04, 0, 0);
        exp_beat(1, 32'h1003, 8'h08, 0, 0);
        exp_beat(1, 32'h1004, 8'h10, 1, 0);
        send_req(32'h1005, 8'd7, 3'd0, 2'd2);
        wait_drain();

        // 3: FIXED with a stalling consumer
        cur_id = 5'd12; cur_user = 1'b1;
        rdy_mode = 1;
        for (int i = 0; i < 4; i++) exp_beat(1, 32'h40, 8'h01, i == 3, 0);
        send_req(32'h40, 8'd3, 3'd0, 2'd0);
        wait_drain();
        rdy_mode = 0;

        // 4: illegal bursts still produce len+1 beats
        cur_id = 5'd1; cur_user = 1'b0;
        exp_beat(1, 32'h0FF8, 8'hFF, 0, 1);
        exp_beat(1, 32'h1000, 8'hFF, 1, 1);
        send_req(32'h0FF8, 8'd1, 3'd3, 2'd1);
        cur_id = 5'd2;
        exp_beat(0, 32'h0, 8'h0, 0, 1);
        exp_beat(0, 32'h0, 8'h0, 1, 1);
        send_req(32'h100, 8'd1, 3'd2, 2'd3);
        cur_id = 5'd4;
        exp_beat(1, 32'h200, 8'hFF, 0, 1);
        exp_beat(1, 32'h208, 8'hFF, 1, 1);
        send_req(32'h200, 8'd1, 3'd4, 2'd1);
        cur_id = 5'd5;
        exp_beat(1, 32'h300, 8'h0F, 0, 1);
        exp_beat(1, 32'h304, 8'hF0, 0, 1);
        exp_beat(1, 32'h308, 8'h0F, 1, 1);
        send_req(32'h300, 8'd2, 3'd2, 2'd2);
        wait_drain();

        // 5: back-to-back bursts with no bubble
        fork
            begin
                for (int c = 0; c < 100 && !b2b_seen; c++) begin
                    @(negedge clk);
                    if (o_beat_valid && i_beat_ready && o_beat_last && o_beat_addr == 32'h3008) begin
                        check("b2b_req_ready", 64'(o_req_ready), 64'd1);
                        @(negedge clk);
                        check("b2b_next_valid", 64'(o_beat_valid), 64'd1);
                        check("b2b_next_addr",  64'(o_beat_addr),  64'h4004);
                        b2b_seen = 1'b1;
                    end
                end
            end
        join_none
        cur_id = 5'd17; cur_user = 1'b1;
        exp_beat(1, 32'h3000, 8'hFF, 0, 0);
        exp_beat(1, 32'h3008, 8'hFF, 1, 0);
        send_req(32'h3000, 8'd1, 3'd3, 2'd1);
        cur_id = 5'd18; cur_user = 1'b0;
        exp_beat(1, 32'h4004, 8'hF0, 1, 0);
        send_req(32'h4004, 8'd0, 3'd2, 2'd1);
        wait_drain();
        check("b2b_seen", 64'(b2b_seen), 64'd1);

        // 6: reset during beat 2 of an 8-beat INCR
        cur_id = 5'd21; cur_user = 1'b1;
        base = beats_seen;
        exp_beat(1, 32'h5000, 8'hFF, 0, 0);
        exp_beat(1, 32'h5008, 8'hFF, 0, 0);
        send_req(32'h5000, 8'd7, 3'd3, 2'd1);
        for (int c = 0; c < 50 && beats_seen < base + 2; c++) begin
            @(negedge clk); #1;
        end
        rdy_mode = 2;
        @(posedge clk); #3;
        check("mid_beat2_valid", 64'(o_beat_valid), 64'd1);
        check("mid_beat2_addr",  64'(o_beat_addr),  64'h5010);
        rst = 1'b1;
        #1;
        check("mid_rst_valid",     64'(o_beat_valid), 64'd0);
        check("mid_rst_req_ready", 64'(o_req_ready),  64'd0);
        check("mid_rst_last",      64'(o_beat_last),  64'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        rdy_mode = 0;
        @(posedge clk); #2;
        check("post_rst_req_ready", 64'(o_req_ready), 64'd1);
        base = beats_seen;
        repeat (20) @(posedge clk);
        #2;
        check("no_stale_beats", 64'(beats_seen - base), 64'd0);
        check("post_rst_valid", 64'(o_beat_valid), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
